// File: rtl/pdp8_kl8.sv
// pdp8_kl8: KL8E-style console teletype for the PDP-8 IOT bus (keyboard 03, printer 04), 8N1 framing.
// Build option KL8_LOOPBACK_EN: the RX synchroniser samples the internal txd instead of the rxd pin.
module pdp8_kl8 #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  io_select,
  input  logic [2:0]  io_op,
  input  logic        io_strobe,
  input  logic [11:0] io_data_in,
  output logic [11:0] io_data_out,
  output logic        io_skip,
  output logic        io_clear_ac,
  output logic        io_interrupt,
  input  logic        rxd,
  output logic        txd
);

  // state    | meaning
  // RX_IDLE  | line idle, waiting for a falling edge
  // RX_START | timing to mid start bit, false start returns to idle
  // RX_DATA  | sampling 8 data bits LSB first, one per bit time
  // RX_STOP  | mid stop bit: high loads the character, low discards it
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  logic [7:0]    kbd_buf;
  logic          kbd_flag;
  logic          tpr_flag;
  logic          int_en;

  logic          tx_busy;
  logic [8:0]    tx_shift;
  logic [3:0]    tx_bits;
  logic [CW-1:0] tx_cnt;
  logic          tx_start;
  logic          tx_done;

  logic          rx_src;
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bits;
  logic [7:0]    rx_shift;
  logic          rx_done;

  logic kbd_hit, tpr_hit;
  logic kcf, ksf, kcc, krs, kie, krb;
  logic tfl, tsf, tcf, tpc, tsk, tls;

  assign kbd_hit = io_strobe && (io_select == 6'o03);
  assign tpr_hit = io_strobe && (io_select == 6'o04);

  assign kcf = kbd_hit && (io_op == 3'o0);
  assign ksf = kbd_hit && (io_op == 3'o1);
  assign kcc = kbd_hit && (io_op == 3'o2);
  assign krs = kbd_hit && (io_op == 3'o4);
  assign kie = kbd_hit && (io_op == 3'o5);
  assign krb = kbd_hit && (io_op == 3'o6);

  assign tfl = tpr_hit && (io_op == 3'o0);
  assign tsf = tpr_hit && (io_op == 3'o1);
  assign tcf = tpr_hit && (io_op == 3'o2);
  assign tpc = tpr_hit && (io_op == 3'o4);
  assign tsk = tpr_hit && (io_op == 3'o5);
  assign tls = tpr_hit && (io_op == 3'o6);

  always_comb begin
    io_data_out = 12'o0000;
    io_skip     = 1'b0;
    io_clear_ac = 1'b0;
    if ((ksf && kbd_flag) || (tsf && tpr_flag) || (tsk && (kbd_flag || tpr_flag)))
      io_skip = 1'b1;
    if (kcc || krb)
      io_clear_ac = 1'b1;
    if (krs || krb)
      io_data_out = {4'b0000, kbd_buf};
  end

  assign io_interrupt = int_en & (kbd_flag | tpr_flag);

`ifdef KL8_LOOPBACK_EN
  logic unused_inputs;
  assign unused_inputs = ^{io_data_in[11:8], rxd};
  assign rx_src = txd;
`else
  logic unused_inputs;
  assign unused_inputs = ^io_data_in[11:8];
  assign rx_src = rxd;
`endif

  // Frame completion sets a flag even if an IOT clears it on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_buf  <= 8'h00;
      kbd_flag <= 1'b0;
      tpr_flag <= 1'b0;
      int_en   <= 1'b1;
    end else begin
      if (rx_done) begin
        kbd_buf  <= rx_shift;
        kbd_flag <= 1'b1;
      end else if (kcf || kcc || krb) begin
        kbd_flag <= 1'b0;
      end
      if (tx_done || tfl)
        tpr_flag <= 1'b1;
      else if (tcf || tls)
        tpr_flag <= 1'b0;
      if (kie)
        int_en <= io_data_in[0];
    end
  end

  // A TPC/TLS while a frame is in flight is dropped.
  assign tx_start = (tpc || tls) && !tx_busy;
  assign tx_done  = tx_busy && (tx_cnt == '0) && (tx_bits == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= 9'h000;
      tx_bits  <= 4'd0;
      tx_cnt   <= '0;
    end else if (tx_start) begin
      txd      <= 1'b0;
      tx_busy  <= 1'b1;
      tx_shift <= {1'b1, io_data_in[7:0]};
      tx_bits  <= 4'd9;
      tx_cnt   <= BIT_LAST;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_bits != 4'd0) begin
        txd      <= tx_shift[0];
        tx_shift <= {1'b0, tx_shift[8:1]};
        tx_bits  <= tx_bits - 1'b1;
        tx_cnt   <= BIT_LAST;
      end else begin
        txd     <= 1'b1;
        tx_busy <= 1'b0;
      end
    end
  end

  assign rx_done = (rx_state == RX_STOP) && (rx_cnt == '0) && rx_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      rx_s1   <= rx_src;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else if (rx_s2) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_state <= RX_DATA;
            rx_cnt   <= BIT_LAST;
            rx_bits  <= 3'd7;
          end
        end
        RX_DATA: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_bits == 3'd0)
              rx_state <= RX_STOP;
            else
              rx_bits <= rx_bits - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt != '0)
            rx_cnt <= rx_cnt - 1'b1;
          else
            rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp8_kl8.sv
// tb_pdp8_kl8: directed stimulus for pdp8_kl8 with a frame-level behavioural model checked every cycle.
// Define KL8_LOOPBACK_EN for both files to exercise the loopback build.
module tb_pdp8_kl8;

  localparam int BD = 8;
  // two synchroniser stages plus edge detect, then 9.5 bit times to mid stop bit
  localparam int RX_LAT = 3 + BD / 2 + 9 * BD;
`ifdef KL8_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  io_select = 6'o00;
  logic [2:0]  io_op = 3'o0;
  logic        io_strobe = 1'b0;
  logic [11:0] io_data_in = 12'o0000;
  logic [11:0] io_data_out;
  logic        io_skip;
  logic        io_clear_ac;
  logic        io_interrupt;
  logic        rxd = 1'b1;
  logic        txd;

  int n_cmp = 0;
  int n_err = 0;

  pdp8_kl8 #(.BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset),
    .io_select(io_select), .io_op(io_op), .io_strobe(io_strobe),
    .io_data_in(io_data_in), .io_data_out(io_data_out),
    .io_skip(io_skip), .io_clear_ac(io_clear_ac), .io_interrupt(io_interrupt),
    .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int edge_n;
  always @(posedge clk) cyc <= cyc + 1;
  assign edge_n = cyc + 1;

  // ---- behavioural model ----
  logic       m_kbd, m_tpr, m_int;
  logic [7:0] m_buf;
  logic       m_busy;
  int         m_age;
  logic [9:0] m_frame;
  logic       lb_valid;
  int         lb_edge;
  logic [7:0] lb_data;
  logic       rx_exp_valid = 1'b0;
  int         rx_exp_edge = 0;
  logic [7:0] rx_exp_data = 8'h00;

  logic [8:0] code;
  logic       stb, tx_fin, rx_fin;
  logic [7:0] rx_fin_data;
  assign code   = {io_select, io_op};
  assign stb    = io_strobe;
  assign tx_fin = m_busy && (m_age == 10 * BD - 1);
  assign rx_fin = LB ? (lb_valid && edge_n == lb_edge) : (rx_exp_valid && edge_n == rx_exp_edge);
  assign rx_fin_data = LB ? lb_data : rx_exp_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_kbd <= 1'b0; m_tpr <= 1'b0; m_int <= 1'b1; m_buf <= 8'h00;
      m_busy <= 1'b0; m_age <= 0; m_frame <= 10'h3ff;
      lb_valid <= 1'b0; lb_edge <= 0; lb_data <= 8'h00;
    end else begin
      if (rx_fin) begin
        m_kbd <= 1'b1;
        m_buf <= rx_fin_data;
      end else if (stb && (code == 9'o030 || code == 9'o032 || code == 9'o036)) begin
        m_kbd <= 1'b0;
      end
      if (tx_fin || (stb && code == 9'o040)) m_tpr <= 1'b1;
      else if (stb && (code == 9'o042 || code == 9'o046)) m_tpr <= 1'b0;
      if (stb && code == 9'o035) m_int <= io_data_in[0];
      if (!m_busy && stb && (code == 9'o044 || code == 9'o046)) begin
        m_busy   <= 1'b1;
        m_age    <= 0;
        m_frame  <= {1'b1, io_data_in[7:0], 1'b0};
        lb_valid <= 1'b1;
        lb_edge  <= edge_n + RX_LAT;
        lb_data  <= io_data_in[7:0];
      end else if (m_busy) begin
        if (tx_fin) m_busy <= 1'b0;
        else m_age <= m_age + 1;
      end
    end
  end

  logic        e_txd, e_skip, e_clr, e_int;
  logic [11:0] e_dout;
  always_comb begin
    e_txd = 1'b1; e_skip = 1'b0; e_clr = 1'b0; e_dout = 12'o0000;
    if (m_busy) e_txd = m_frame[m_age / BD];
    e_int = m_int & (m_kbd | m_tpr);
    if (io_strobe) begin
      case (code)
        9'o031: e_skip = m_kbd;
        9'o032: e_clr = 1'b1;
        9'o034: e_dout = {4'b0000, m_buf};
        9'o036: begin e_clr = 1'b1; e_dout = {4'b0000, m_buf}; end
        9'o041: e_skip = m_tpr;
        9'o045: e_skip = m_kbd | m_tpr;
        default: e_skip = 1'b0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o expected %0o at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("txd", {11'b0, txd}, {11'b0, e_txd});
    chk("io_interrupt", {11'b0, io_interrupt}, {11'b0, e_int});
    chk("io_skip", {11'b0, io_skip}, {11'b0, e_skip});
    chk("io_clear_ac", {11'b0, io_clear_ac}, {11'b0, e_clr});
    chk("io_data_out", io_data_out, e_dout);
  end

  // ---- stimulus ----
  logic        s_skip, s_clr;
  logic [11:0] s_dout;

  task automatic strobe_on(input logic [8:0] c, input logic [11:0] ac);
    io_select = c[8:3]; io_op = c[2:0]; io_data_in = ac; io_strobe = 1'b1;
  endtask

  task automatic iot(input logic [8:0] c, input logic [11:0] ac);
    @(posedge clk); #1;
    strobe_on(c, ac);
    #1;
    s_skip = io_skip; s_clr = io_clear_ac; s_dout = io_data_out;
    @(posedge clk); #1;
    io_strobe = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    @(posedge clk); #1;
    rx_exp_edge  = cyc + RX_LAT;
    rx_exp_data  = d;
    rx_exp_valid = stop_bit;
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
  endtask

  // Issue one IOT exactly on the edge the frame completes.
  task automatic rx_iot(input logic [7:0] d, input logic [8:0] c, input logic [11:0] x_dout, input string nm);
    fork
      rx_frame(d, 1'b1);
      begin
        @(posedge clk);
        repeat (RX_LAT - 1) @(posedge clk);
        #1; strobe_on(c, 12'o0000);
        #1; chk({nm, "_dout"}, io_data_out, x_dout);
        chk({nm, "_clr"}, {11'b0, io_clear_ac}, 12'o0001);
        @(posedge clk); #1; io_strobe = 1'b0;
      end
    join
  endtask

  initial begin
    logic [9:0] pat;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // idle after reset
    repeat (100) @(posedge clk);
    #2;
    chk("idle_txd", {11'b0, txd}, 12'o0001);
    chk("idle_int", {11'b0, io_interrupt}, 12'o0000);
    iot(9'o031, 12'o0000); chk("idle_ksf", {11'b0, s_skip}, 12'o0000);
    iot(9'o041, 12'o0000); chk("idle_tsf", {11'b0, s_skip}, 12'o0000);
    iot(9'o034, 12'o0000); chk("idle_krs", s_dout, 12'o0000);
    iot(9'o035, 12'o0000);
    iot(9'o040, 12'o0000);
    #2 chk("kie0_int", {11'b0, io_interrupt}, 12'o0000);
    iot(9'o041, 12'o0000); chk("tfl_tsf", {11'b0, s_skip}, 12'o0001);
    iot(9'o042, 12'o0000);
    iot(9'o035, 12'o0001);

    // TLS 0101: start, 1,0,0,0,0,0,1,0, stop
    iot(9'o046, 12'o0101);
    pat = 10'b1010000010;
    repeat (4) @(posedge clk);
    #2 chk("tx_bit0", {11'b0, txd}, {11'b0, pat[0]});
    for (int k = 1; k < 10; k++) begin
      repeat (8) @(posedge clk);
      #2 chk("tx_bit", {11'b0, txd}, {11'b0, pat[k]});
    end
    repeat (3) @(posedge clk);
    #1 strobe_on(9'o041, 12'o0000);
    #1 chk("tsf_before", {11'b0, io_skip}, 12'o0000);
    @(posedge clk);
    #1 chk("tsf_after", {11'b0, io_skip}, 12'o0001);
    chk("tx_int", {11'b0, io_interrupt}, 12'o0001);
    io_strobe = 1'b0;
    repeat (20) @(posedge clk);

`ifdef KL8_LOOPBACK_EN
    iot(9'o030, 12'o0000);
    iot(9'o046, 12'o0063);
    repeat (100) @(posedge clk);
    iot(9'o031, 12'o0000); chk("lb_ksf", {11'b0, s_skip}, 12'o0001);
    iot(9'o034, 12'o0000); chk("lb_krs", s_dout, 12'o0063);
`else
    // receive 0x5A
    rx_frame(8'h5a, 1'b1);
    repeat (5) @(posedge clk);
    iot(9'o031, 12'o0000); chk("rx_ksf", {11'b0, s_skip}, 12'o0001);
    iot(9'o036, 12'o0000);
    chk("krb_clr", {11'b0, s_clr}, 12'o0001);
    chk("krb_dout", s_dout, 12'o0132);
    iot(9'o031, 12'o0000); chk("krb_ksf", {11'b0, s_skip}, 12'o0000);

    // glitch, then framing error
    @(posedge clk); #1 rxd = 1'b0;
    repeat (2) @(posedge clk); #1 rxd = 1'b1;
    repeat (100) @(posedge clk);
    iot(9'o031, 12'o0000); chk("glitch_ksf", {11'b0, s_skip}, 12'o0000);
    rx_frame(8'h33, 1'b0);
    repeat (20) @(posedge clk);
    iot(9'o031, 12'o0000); chk("frame_err_ksf", {11'b0, s_skip}, 12'o0000);

    // second TPC while busy is dropped
    iot(9'o044, 12'o0101);
    iot(9'o044, 12'o0102);
    repeat (10) @(posedge clk);
    #2 chk("drop_bit0", {11'b0, txd}, 12'o0001);
    repeat (8) @(posedge clk);
    #2 chk("drop_bit1", {11'b0, txd}, 12'o0000);
    repeat (100) @(posedge clk);

    // KRB / KCC on the completion edge
    rx_iot(8'hc3, 9'o036, 12'o0132, "krb_edge");
    repeat (5) @(posedge clk);
    iot(9'o031, 12'o0000); chk("krb_edge_ksf", {11'b0, s_skip}, 12'o0001);
    iot(9'o034, 12'o0000); chk("krb_edge_krs", s_dout, 12'o0303);
    iot(9'o030, 12'o0000);
    rx_iot(8'h0f, 9'o032, 12'o0000, "kcc_edge");
    repeat (5) @(posedge clk);
    iot(9'o031, 12'o0000); chk("kcc_edge_ksf", {11'b0, s_skip}, 12'o0001);
`endif

    // reset mid-frame
    iot(9'o046, 12'o0000);
    iot(9'o040, 12'o0000);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("rst_txd", {11'b0, txd}, 12'o0001);
    chk("rst_int", {11'b0, io_interrupt}, 12'o0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    iot(9'o045, 12'o0000); chk("rst_tsk", {11'b0, s_skip}, 12'o0000);
    repeat (120) @(posedge clk);
    #2 chk("rst_idle_txd", {11'b0, txd}, 12'o0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
